// File: rtl/eq_ctrl_pkg.sv
// rtl/eq_ctrl_pkg.sv - shared types and constants for the EQ setting controller
package eq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEVEL = 3'd1,
    ST_BAND  = 3'd2,
    ST_GAIN  = 3'd3
  } state_e;

  localparam int BAND_W       = 3;
  localparam int GAIN_W_DEF   = 16;
  localparam int GAIN_MAX_DEF = 12;
  localparam int GAIN_MIN_DEF = -12;

  // Band code 0 on the update channel addresses every band at once.
  localparam logic [BAND_W-1:0] BAND_ALL = '0;

  typedef struct packed {
    logic [BAND_W-1:0]     band;
    logic [GAIN_W_DEF-1:0] gain;
  } upd_t;

  // Next band in 1..num_bands, wrapping at both ends.
  function automatic logic [BAND_W-1:0] band_step(input logic [BAND_W-1:0] band,
                                                  input logic              up,
                                                  input int                num_bands);
    logic [BAND_W-1:0] last;
    last = BAND_W'(num_bands);
    if (up) begin
      band_step = (band >= last) ? BAND_W'(1) : band + BAND_W'(1);
    end else begin
      band_step = (band <= BAND_W'(1)) ? last : band - BAND_W'(1);
    end
  endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// rtl/eq_gain_bank.sv - per-band gain registers with saturating +/-1 step and clear-all
module eq_gain_bank
  import eq_ctrl_pkg::*;
#(
  parameter int NUM_BANDS = 6,
  parameter int GAIN_W    = 16,
  parameter int GAIN_MAX  = 12,
  parameter int GAIN_MIN  = -12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_en_i,
  input  logic              step_up_i,
  input  logic [BAND_W-1:0] step_band_i,
  output logic              step_ok_o,
  output logic [GAIN_W-1:0] step_val_o,
  input  logic [BAND_W-1:0] rd_band_i,
  output logic [GAIN_W-1:0] rd_gain_o
);

  localparam logic signed [GAIN_W-1:0] LIM_HI = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] LIM_LO = GAIN_W'(GAIN_MIN);
  localparam logic signed [GAIN_W-1:0] ONE    = GAIN_W'(1);

  logic signed [GAIN_W-1:0] gain_q [NUM_BANDS];
  logic        [BAND_W-1:0] step_idx;
  logic        [BAND_W-1:0] rd_idx;
  logic signed [GAIN_W-1:0] cur;

  assign step_idx = step_band_i - BAND_W'(1);
  assign rd_idx   = rd_band_i - BAND_W'(1);
  assign cur      = gain_q[step_idx];

  // A step is only legal when it stays inside the gain limits; at a limit it is a no-op.
  always_comb begin
    step_ok_o  = step_up_i ? (cur < LIM_HI) : (cur > LIM_LO);
    step_val_o = step_up_i ? cur + ONE : cur - ONE;
  end

  assign rd_gain_o = gain_q[rd_idx];

  // Gain storage: clear-all wins over a single-band step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_BANDS; i++) gain_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_BANDS; i++) gain_q[i] <= '0;
    end else if (step_en_i && step_ok_o) begin
      gain_q[step_idx] <= step_val_o;
    end
  end

endmodule

// File: rtl/eq_setting_ctrl.sv
// rtl/eq_setting_ctrl.sv - key-driven EQ UI controller; optional idle timeout via EQ_IDLE_TIMEOUT_EN
module eq_setting_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int NUM_BANDS   = 6,
  parameter int GAIN_MAX    = 12,
  parameter int GAIN_MIN    = -12,
  parameter int GAIN_W      = 16,
  parameter int TIMEOUT_CYC = 600000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_mode,
  input  logic              i_key_up,
  input  logic              i_key_down,
  input  logic              i_key_clr,
  output logic [2:0]        o_state,
  output logic [2:0]        o_band,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_upd_valid,
  output logic [2:0]        o_upd_band,
  output logic [GAIN_W-1:0] o_upd_gain,
  input  logic              i_upd_ready
);

  state_e            state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic              upd_valid_q, upd_valid_d;
  logic [BAND_W-1:0] upd_band_q, upd_band_d;
  logic [GAIN_W-1:0] upd_gain_q, upd_gain_d;

  logic              busy;
  logic              mode_hit;
  logic              ud_hit;
  logic              step_req;
  logic              clr_req;
  logic              step_ok;
  logic [GAIN_W-1:0] step_val;
  logic              timeout_hit;

  // A pending update the consumer has not taken freezes gain-changing keys so the
  // payload on the channel always matches the bank.
  assign busy     = upd_valid_q & ~i_upd_ready;
  // A clr pulse owns its cycle even when backpressure makes it a no-op.
  assign mode_hit = i_key_mode & ~i_key_clr;
  assign ud_hit   = (i_key_up ^ i_key_down) & ~i_key_mode & ~i_key_clr;
  assign step_req = ud_hit & (state_q == ST_GAIN) & ~busy;
  assign clr_req  = i_key_clr & ~busy;

  eq_gain_bank #(
    .NUM_BANDS (NUM_BANDS),
    .GAIN_W    (GAIN_W),
    .GAIN_MAX  (GAIN_MAX),
    .GAIN_MIN  (GAIN_MIN)
  ) u_bank (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .clr_i       (clr_req),
    .step_en_i   (step_req),
    .step_up_i   (i_key_up),
    .step_band_i (band_q),
    .step_ok_o   (step_ok),
    .step_val_o  (step_val),
    .rd_band_i   (band_q),
    .rd_gain_o   (o_gain)
  );

`ifdef EQ_IDLE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] TO_SAT  = 32'(TIMEOUT_CYC);

  logic        any_key;
  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign any_key = i_key_mode | i_key_up | i_key_down | i_key_clr;

  // Idle counter: cleared by any key, holds at the limit instead of wrapping.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (any_key) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_SAT) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end

  assign timeout_hit = ~any_key & (idle_cnt_q >= TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Display FSM: mode walks IDLE->LEVEL->BAND->GAIN then toggles BAND/GAIN.
  always_comb begin
    state_d = state_q;
    if (mode_hit) begin
      case (state_q)
        ST_IDLE:  state_d = ST_LEVEL;
        ST_LEVEL: state_d = ST_BAND;
        ST_BAND:  state_d = ST_GAIN;
        ST_GAIN:  state_d = ST_BAND;
        default:  state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  // Band selection moves only in BAND state and is never reported on the update channel.
  always_comb begin
    band_d = band_q;
    if (ud_hit && (state_q == ST_BAND)) begin
      band_d = band_step(band_q, i_key_up, NUM_BANDS);
    end
  end

  // Update channel: a transfer retires the payload unless a new one loads in the same cycle.
  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_band_d  = upd_band_q;
    upd_gain_d  = upd_gain_q;
    if (upd_valid_q && i_upd_ready) begin
      upd_valid_d = 1'b0;
    end
    if (clr_req) begin
      upd_valid_d = 1'b1;
      upd_band_d  = BAND_ALL;
      upd_gain_d  = '0;
    end else if (step_req && step_ok) begin
      upd_valid_d = 1'b1;
      upd_band_d  = band_q;
      upd_gain_d  = step_val;
    end
  end

  // Control and update-channel registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      band_q      <= BAND_W'(1);
      upd_valid_q <= 1'b0;
      upd_band_q  <= '0;
      upd_gain_q  <= '0;
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      upd_valid_q <= upd_valid_d;
      upd_band_q  <= upd_band_d;
      upd_gain_q  <= upd_gain_d;
    end
  end

  assign o_state     = state_q;
  assign o_band      = band_q;
  assign o_upd_valid = upd_valid_q;
  assign o_upd_band  = upd_band_q;
  assign o_upd_gain  = upd_gain_q;

endmodule
